inst_fetch_buf: RTL and testbench



---
 rtl/inst_fetch_buf.sv | 121 ++++++++++++
 tb/tb_inst_fetch_buf.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buf.sv
// rtl/inst_fetch_buf.sv - instruction fetch front end: PC owner, BRAM reader and decode FIFO
// Optional feature macro: IF_PERF_CNT_EN (adds perf_fetch_o / perf_stall_o counters)
module inst_fetch_buf #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 10,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i,
    output logic [31:0]       inst_o,
    output logic [31:0]       pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic              redirect_i,
`ifdef IF_PERF_CNT_EN
    input  logic [31:0]       redirect_pc_i,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_stall_o
`else
    input  logic [31:0]       redirect_pc_i
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q;
    logic [31:0]   req_pc;
    logic          inflight;
    logic          discard;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occ;
    logic          head_valid;

    assign head_valid = (count != '0);
    assign valid_o    = head_valid & ~redirect_i & ~rst;
    assign pop        = valid_o & ready_i;
    // A response is kept only if it belongs to the current fetch stream.
    assign push       = inflight & ~discard & ~redirect_i & ~rst;

    // Occupancy counts the in-flight word too, so a response always has a free slot.
    assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign issue = ~rst & ~redirect_i & (occ < (CW+1)'(DEPTH));

    assign rom_ce_o   = issue;
    assign rom_addr_o = pc_q[ROM_AW+1:2];
    assign inst_o     = head_valid ? inst_mem[rd_ptr] : 32'h0;
    assign pc_o       = head_valid ? pc_mem[rd_ptr]   : 32'h0;

    // PC and in-flight tracking; redirect takes priority over issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc   <= 32'h0;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else if (redirect_i) begin
            pc_q     <= redirect_pc_i & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            discard  <= inflight;
        end else begin
            inflight <= issue;
            discard  <= 1'b0;
            if (issue) begin
                req_pc <= pc_q;
                pc_q   <= pc_q + 32'd4;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect flushes everything buffered.
    always_ff @(posedge clk) begin
        if (rst || redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= rom_data_i;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

    // Overflow cannot happen because issue reserves a slot ahead of the response.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !pop && count == CW'(DEPTH)));
    end

`ifdef IF_PERF_CNT_EN
    // Delivered-instruction and empty-head cycle counters, frozen while redirecting.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_o <= 32'h0;
            perf_stall_o <= 32'h0;
        end else if (!redirect_i) begin
            if (pop)      perf_fetch_o <= perf_fetch_o + 32'd1;
            if (!valid_o) perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_buf.sv
// tb/tb_inst_fetch_buf.sv - directed testbench for inst_fetch_buf
module tb_inst_fetch_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        rom_ce, w_rom_ce;
    logic [9:0]  rom_addr, w_rom_addr;
    logic [31:0] rom_data = 32'h0, w_rom_data = 32'h0;
    logic [31:0] inst, w_inst;
    logic [31:0] pc, w_pc;
    logic        valid, w_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_stall, w_perf_fetch, w_perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_fetch_buf #(.RESET_PC(32'h0000_0000), .ROM_AW(10), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .inst_o(inst), .pc_o(pc), .valid_o(valid), .ready_i(ready),
        .redirect_i(redirect),
`ifdef IF_PERF_CNT_EN
        .redirect_pc_i(redirect_pc),
        .perf_fetch_o(perf_fetch), .perf_stall_o(perf_stall)
`else
        .redirect_pc_i(redirect_pc)
`endif
    );

    inst_fetch_buf #(.RESET_PC(32'hFFFF_FFF8), .ROM_AW(10), .DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst),
        .rom_ce_o(w_rom_ce), .rom_addr_o(w_rom_addr), .rom_data_i(w_rom_data),
        .inst_o(w_inst), .pc_o(w_pc), .valid_o(w_valid), .ready_i(1'b1),
        .redirect_i(1'b0),
`ifdef IF_PERF_CNT_EN
        .redirect_pc_i(32'h0),
        .perf_fetch_o(w_perf_fetch), .perf_stall_o(w_perf_stall)
`else
        .redirect_pc_i(32'h0)
`endif
    );

    // ROM models: word n holds 0x1000_0000 + n, one-cycle read latency.
    always @(posedge clk) begin
        if (rom_ce)   rom_data   <= 32'h1000_0000 + {22'h0, rom_addr};
        if (w_rom_ce) w_rom_data <= 32'h1000_0000 + {22'h0, w_rom_addr};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst = r; ready = rdy; redirect = rd; redirect_pc = rpc;
        #1;
    endtask

    initial begin
        // reset state
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_ce", {31'h0, rom_ce}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_addr", {22'h0, rom_addr}, 32'h0);
        check("rst_waddr", {22'h0, w_rom_addr}, 32'h3FE);

        // streaming start
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c1
        check("c1_ce", {31'h0, rom_ce}, 32'h1);
        check("c1_addr", {22'h0, rom_addr}, 32'h0);
        check("c1_valid", {31'h0, valid}, 32'h0);
        check("c1_waddr", {22'h0, w_rom_addr}, 32'h3FE);
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c2
        check("c2_addr", {22'h0, rom_addr}, 32'h1);
        check("c2_valid", {31'h0, valid}, 32'h0);
        check("c2_waddr", {22'h0, w_rom_addr}, 32'h3FF);
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c3
        check("c3_valid", {31'h0, valid}, 32'h1);
        check("c3_pc", pc, 32'h0);
        check("c3_inst", inst, 32'h1000_0000);
        check("c3_waddr", {22'h0, w_rom_addr}, 32'h0);
        check("c3_wpc", w_pc, 32'hFFFF_FFF8);

        // back-pressure for five cycles
        tick(1'b0, 1'b0, 1'b0, 32'h0);                          // c4
        check("c4_pc", pc, 32'h4);
        check("c4_inst", inst, 32'h1000_0001);
        check("c4_ce", {31'h0, rom_ce}, 32'h0);
        check("c4_wpc", w_pc, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) begin                        // c5..c8
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            check("hold_pc", pc, 32'h4);
            check("hold_inst", inst, 32'h1000_0001);
            check("hold_valid", {31'h0, valid}, 32'h1);
            check("hold_ce", {31'h0, rom_ce}, 32'h0);
            if (i == 0) check("c5_wpc", w_pc, 32'h0);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c9
        check("c9_pc", pc, 32'h4);
        check("c9_ce", {31'h0, rom_ce}, 32'h1);
        check("c9_addr", {22'h0, rom_addr}, 32'h3);
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c10
        check("c10_pc", pc, 32'h8);
        check("c10_inst", inst, 32'h1000_0002);

        // redirect with a word in flight
        tick(1'b0, 1'b1, 1'b1, 32'h0000_0043);                  // c11
        check("c11_valid", {31'h0, valid}, 32'h0);
        check("c11_ce", {31'h0, rom_ce}, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c12
        check("c12_ce", {31'h0, rom_ce}, 32'h1);
        check("c12_addr", {22'h0, rom_addr}, 32'h10);
        check("c12_valid", {31'h0, valid}, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c13
        check("c13_addr", {22'h0, rom_addr}, 32'h11);
        check("c13_valid", {31'h0, valid}, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c14
        check("c14_valid", {31'h0, valid}, 32'h1);
        check("c14_pc", pc, 32'h40);
        check("c14_inst", inst, 32'h1000_0010);
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c15
        check("c15_pc", pc, 32'h44);
        check("c15_inst", inst, 32'h1000_0011);

        // back-to-back redirects
        tick(1'b0, 1'b1, 1'b1, 32'h0000_0080);                  // c16
        check("c16_valid", {31'h0, valid}, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h0000_0100);                  // c17
        check("c17_valid", {31'h0, valid}, 32'h0);
        check("c17_ce", {31'h0, rom_ce}, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c18
        check("c18_addr", {22'h0, rom_addr}, 32'h40);
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c19
        check("c19_valid", {31'h0, valid}, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c20
        check("c20_pc", pc, 32'h100);
        check("c20_inst", inst, 32'h1000_0040);
`ifdef IF_PERF_CNT_EN
        check("c20_perf_fetch", perf_fetch, 32'd5);
        check("c20_perf_stall", perf_stall, 32'd6);
`endif

        // reset pulse mid-stream
        tick(1'b1, 1'b1, 1'b0, 32'h0);                          // c21
        check("c21_ce", {31'h0, rom_ce}, 32'h0);
        check("c21_valid", {31'h0, valid}, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c22
        check("c22_valid", {31'h0, valid}, 32'h0);
        check("c22_pc", pc, 32'h0);
        check("c22_inst", inst, 32'h0);
        check("c22_ce", {31'h0, rom_ce}, 32'h1);
        check("c22_addr", {22'h0, rom_addr}, 32'h0);
`ifdef IF_PERF_CNT_EN
        check("c22_perf_fetch", perf_fetch, 32'd0);
        check("c22_perf_stall", perf_stall, 32'd0);
`endif
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c23
        check("c23_valid", {31'h0, valid}, 32'h0);
        check("c23_addr", {22'h0, rom_addr}, 32'h1);
        tick(1'b0, 1'b1, 1'b0, 32'h0);                          // c24
        check("c24_valid", {31'h0, valid}, 32'h1);
        check("c24_pc", pc, 32'h0);
        check("c24_inst", inst, 32'h1000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
